// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer scan-out engine.
// Derives a pixel strobe from the system clock, generates VGA timing,
// issues one framebuffer read per visible pixel and expands RGB332 to 8/8/8.
// Sync and blank travel through a delay line matching the read latency.
module vga_scanout #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned FB_LATENCY = 2,
   parameter int unsigned ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              fb_rd,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [7:0]        fb_data,
   output logic              VGA_CLK,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   logic              phase;
   logic              tick;
   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic [ADDR_W-1:0] addr;
   logic              visible;
   logic              hs_n;
   logic              vs_n;
   logic              frame_top;
   logic [2:0]        dly [FB_LATENCY];
   logic [2:0]        tail;
   logic [2:0]        r3;
   logic [2:0]        g3;
   logic [1:0]        b2;

   assign tick      = phase;
   assign VGA_CLK   = phase;
   assign VGA_SYNC_N = 1'b0;

   assign visible   = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
   assign hs_n      = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs_n      = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
   assign frame_top = (h == '0) && (v == '0);

   // Frame start is the tick spent at (0,0); its read uses fb_base directly,
   // so the first pixel after reset or wrap already addresses the new base.
   assign frame_start = tick && frame_top;
   assign fb_rd       = tick && visible;
   assign fb_addr     = frame_start ? fb_base : addr;

   assign tail = dly[FB_LATENCY-1];
   assign r3   = fb_data[7:5];
   assign g3   = fb_data[4:2];
   assign b2   = fb_data[1:0];

   // Pixel phase and horizontal/vertical position counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= 1'b0;
         h     <= '0;
         v     <= '0;
      end else begin
         phase <= ~phase;
         if (tick) begin
            if (h == HW'(H_TOTAL - 1)) begin
               h <= '0;
               v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   // Read address: reload from fb_base at frame start, step once per visible read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr <= '0;
      end else if (frame_start) begin
         addr <= fb_base + ADDR_W'(1);
      end else if (fb_rd) begin
         addr <= addr + ADDR_W'(1);
      end
   end

   // Delay line for {visible, hs_n, vs_n}; cleared to the idle (blank, syncs high) value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FB_LATENCY; i++) dly[i] <= 3'b011;
      end else if (tick) begin
         dly[0] <= {visible, hs_n, vs_n};
         for (int unsigned i = 1; i < FB_LATENCY; i++) dly[i] <= dly[i-1];
      end
   end

   // Output registers: sync/blank from the delay-line tail, colour expanded from fb_data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         VGA_BLANK_N <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else if (tick) begin
         VGA_BLANK_N <= tail[2];
         VGA_HS      <= tail[1];
         VGA_VS      <= tail[0];
         if (tail[2]) begin
            VGA_R <= {r3, r3, r3[2:1]};
            VGA_G <= {g3, g3, g3[2:1]};
            VGA_B <= {b2, b2, b2, b2};
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout with reduced timing so
// whole frames fit in a short run. Two instances: FB_LATENCY 2 and 1.
module tb_vga_scanout;

   localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3;
   localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;   // 16 ticks per line
   localparam int VT = VA + VFP + VSY + VBP;   // 8 lines per frame
   localparam int FT = HT * VT;                // 128 ticks per frame
   localparam int AW = 19;
   localparam logic [AW-1:0] SPECIAL = 19'h0100B;  // pixel (3,1) with base 0x1000

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] fb_base = 19'h01000;
   int            checks = 0;
   int            errors = 0;

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit vis_at(input int t);
      int h, v;
      h = t % HT;
      v = (t / HT) % VT;
      return (h < HA) && (v < VA);
   endfunction

   function automatic bit hs_at(input int t);
      int h;
      h = t % HT;
      return !((h >= HA + HFP) && (h < HA + HFP + HSY));
   endfunction

   function automatic bit vs_at(input int t);
      int v;
      v = (t / HT) % VT;
      return !((v >= VA + VFP) && (v < VA + VFP + VSY));
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 2 : 1;

      logic          fb_rd, vclk, hs, vs, blank_n, sync_n, fs;
      logic [AW-1:0] fb_addr;
      logic [7:0]    fb_data, r, gg, b;
      logic [AW-1:0] pipe [4] = '{default: '0};

      typedef struct {
         logic [23:0] rgb;
         int          t;
      } exp_t;
      exp_t q[$];

      int            cyc;
      logic [AW-1:0] base_frame;
      int            hs_fall, bl_fall;
      bit            prev_hs, prev_bl;
      int            n_hs, n_vs, n_bl, n_rd, n_fs, n_lines;

      vga_scanout #(
         .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
         .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
         .FB_LATENCY(L), .ADDR_W(AW)
      ) dut (
         .clk(clk), .reset(reset), .fb_base(fb_base),
         .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
         .VGA_CLK(vclk), .VGA_R(r), .VGA_G(gg), .VGA_B(b),
         .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
         .VGA_SYNC_N(sync_n), .frame_start(fs)
      );

      // Memory model: data for the address requested L ticks earlier
      always @(posedge clk) begin
         if (vclk) begin
            pipe[0] <= fb_addr;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
         end
      end
      assign fb_data = (pipe[L-1] == SPECIAL) ? 8'hE0 : 8'h1F;

      // Outputs must take reset values as soon as reset rises
      always @(posedge reset) begin
         #1;
         check($sformatf("L%0d rst_hs", L), {31'b0, hs}, 32'd1);
         check($sformatf("L%0d rst_vs", L), {31'b0, vs}, 32'd1);
         check($sformatf("L%0d rst_blank", L), {31'b0, blank_n}, 32'd0);
         check($sformatf("L%0d rst_rgb", L), {8'b0, r, gg, b}, 32'd0);
         check($sformatf("L%0d rst_rd", L), {31'b0, fb_rd}, 32'd0);
         check($sformatf("L%0d rst_addr", L), {13'b0, fb_addr}, 32'd0);
         check($sformatf("L%0d rst_fs", L), {31'b0, fs}, 32'd0);
         check($sformatf("L%0d rst_vclk", L), {31'b0, vclk}, 32'd0);
         check($sformatf("L%0d sync_n", L), {31'b0, sync_n}, 32'd0);
      end

      // Request side pushes expectations; output side pops and compares
      always @(negedge clk) begin
         if (reset) begin
            cyc = 0; q.delete();
            hs_fall = -1; bl_fall = -1; prev_hs = 1'b1; prev_bl = 1'b0;
            n_hs = 0; n_vs = 0; n_bl = 0; n_rd = 0; n_fs = 0; n_lines = 0;
         end else begin
            int  t, h, v, s;
            bit  tk;
            exp_t e;
            logic [AW-1:0] ea;
            cyc++;
            tk = (cyc % 2) == 1;
            t  = (cyc - 1) / 2;
            check($sformatf("L%0d vga_clk", L), {31'b0, vclk}, {31'b0, tk});

            if (tk && t > 0 && (t % FT) == 0) begin
               if (t >= 2 * FT) begin
                  check($sformatf("L%0d hs_low_clk", L), n_hs, 2 * HSY * VT);
                  check($sformatf("L%0d vs_low_clk", L), n_vs, 2 * HT * VSY);
                  check($sformatf("L%0d blank_hi_clk", L), n_bl, 2 * HA * VA);
                  check($sformatf("L%0d blank_lines", L), n_lines, VA);
                  check($sformatf("L%0d rd_per_frame", L), n_rd, HA * VA);
                  check($sformatf("L%0d fs_per_frame", L), n_fs, 1);
               end
               n_hs = 0; n_vs = 0; n_bl = 0; n_rd = 0; n_fs = 0; n_lines = 0;
            end

            if (tk) begin
               h = t % HT;
               v = (t / HT) % VT;
               if (h == 0 && v == 0) base_frame = fb_base;
               check($sformatf("L%0d frame_start", L), {31'b0, fs}, {31'b0, (h == 0 && v == 0)});
               check($sformatf("L%0d fb_rd", L), {31'b0, fb_rd}, {31'b0, vis_at(t)});
               if (fb_rd && vis_at(t)) begin
                  ea = base_frame + AW'(v * HA + h);
                  check($sformatf("L%0d fb_addr", L), {13'b0, fb_addr}, {13'b0, ea});
                  e.rgb = (ea == SPECIAL) ? 24'hFF0000 : 24'h00FFFF;
                  e.t   = t;
                  q.push_back(e);
               end

               s = t - 1 - L;
               check($sformatf("L%0d blank_n", L), {31'b0, blank_n}, {31'b0, (s >= 0) ? vis_at(s) : 1'b0});
               check($sformatf("L%0d hs", L), {31'b0, hs}, {31'b0, (s >= 0) ? hs_at(s) : 1'b1});
               check($sformatf("L%0d vs", L), {31'b0, vs}, {31'b0, (s >= 0) ? vs_at(s) : 1'b1});
               if (blank_n) begin
                  if (q.size() == 0) begin
                     check($sformatf("L%0d pixel_pending", L), 32'd0, 32'd1);
                  end else begin
                     e = q.pop_front();
                     check($sformatf("L%0d pixel_tick", L), s, e.t);
                     check($sformatf("L%0d pixel_rgb", L), {8'b0, r, gg, b}, {8'b0, e.rgb});
                  end
               end else begin
                  check($sformatf("L%0d blank_rgb", L), {8'b0, r, gg, b}, 32'd0);
               end
            end else begin
               check($sformatf("L%0d rd_offtick", L), {31'b0, fb_rd}, 32'd0);
               check($sformatf("L%0d fs_offtick", L), {31'b0, fs}, 32'd0);
            end

            if (!hs) n_hs++;
            if (!vs) n_vs++;
            if (blank_n) n_bl++;
            if (fb_rd) n_rd++;
            if (fs) n_fs++;
            if (!prev_bl && blank_n) n_lines++;
            if (prev_hs && !hs) begin
               if (hs_fall >= 0)
                  check($sformatf("L%0d hs_period", L), cyc - hs_fall, 2 * HT);
               if (bl_fall >= 0 && (cyc - bl_fall) < 2 * HT)
                  check($sformatf("L%0d hs_after_blank", L), cyc - bl_fall, 2 * HFP);
               hs_fall = cyc;
            end
            if (prev_bl && !blank_n) bl_fall = cyc;
            prev_hs = hs;
            prev_bl = blank_n;
         end
      end
   end

   // Stimulus: reset, run, move the base mid-frame, reset mid-line, run again
   initial begin
      #5 reset = 1'b1;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      // frame 1, line 2: new base must only take effect at frame 2
      repeat (321) @(negedge clk);
      #3 fb_base = 19'h40000;
      // frame 3, line 1, pixel 5: reset in the middle of a line
      repeat (490) @(negedge clk);
      #3 reset = 1'b1;
      repeat (3) @(negedge clk);
      #3 fb_base = 19'h01000;
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (4 * FT + 20) @(negedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
